cla_adder: RTL and testbench



---
 rtl/cla_adder.sv | 108 ++++++++++
 tb/tb_cla_adder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: Sum/Cout = A + B + Cin, one cycle latency.
// Define CLA_OVF_EN to add the registered signed-overflow output Ovf.
module cla_adder #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef CLA_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NG = WIDTH / GROUP;

    if (GROUP < 1 || WIDTH % GROUP != 0) begin : g_bad_cfg
        $error("cla_adder: WIDTH (%0d) must be a positive multiple of GROUP (%0d)", WIDTH, GROUP);
    end

    // Carry out of position k, written as a flat sum of products:
    // OR over m<=k of (gv[m] & pv[m+1..k]), plus cin & pv[0..k].
    function automatic logic sop_carry(input logic [WIDTH-1:0] gv,
                                       input logic [WIDTH-1:0] pv,
                                       input logic             cin,
                                       input int               k);
        logic acc;
        logic prod;
        acc = cin;
        for (int n = 0; n <= k; n++) begin
            acc = acc & pv[n];
        end
        for (int m = 0; m <= k; m++) begin
            prod = gv[m];
            for (int n = m + 1; n <= k; n++) begin
                prod = prod & pv[n];
            end
            acc = acc | prod;
        end
        return acc;
    endfunction

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      cg;
    logic [WIDTH-1:0] sum_next;

    genvar gi, ki;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign g[gi]        = A[gi] & B[gi];
            assign p[gi]        = A[gi] ^ B[gi];
            assign sum_next[gi] = p[gi] ^ c[gi];
        end

        assign cg[0] = Cin;

        for (gi = 0; gi < NG; gi++) begin : g_group
            assign gg[gi] = sop_carry(WIDTH'(g[gi*GROUP +: GROUP]),
                                      WIDTH'(p[gi*GROUP +: GROUP]), 1'b0, GROUP - 1);
            assign gp[gi] = &p[gi*GROUP +: GROUP];

            // Second level: each group carry-in depends only on GG/GP and Cin.
            assign cg[gi+1] = sop_carry(WIDTH'(gg), WIDTH'(gp), Cin, gi);

            for (ki = 0; ki < GROUP; ki++) begin : g_carry
                if (ki == 0) begin : g_first
                    assign c[gi*GROUP] = cg[gi];
                end else begin : g_inner
                    assign c[gi*GROUP + ki] = sop_carry(WIDTH'(g[gi*GROUP +: GROUP]),
                                                        WIDTH'(p[gi*GROUP +: GROUP]),
                                                        cg[gi], ki - 1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
`ifdef CLA_OVF_EN
            Ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= sum_next;
                Cout <= cg[NG];
`ifdef CLA_OVF_EN
                Ovf  <= c[WIDTH-1] ^ cg[NG];
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Directed self-checking bench for cla_adder (WIDTH=8, GROUP=4), plus a short random
// sweep against the arithmetic A+B+Cin. Ovf checks are included when CLA_OVF_EN is set.
module tb_cla_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       out_valid;
    logic [7:0] Sum;
    logic       Cout;
`ifdef CLA_OVF_EN
    logic       Ovf;
`endif

    int checks = 0;
    int errors = 0;

    cla_adder #(.WIDTH(8), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef CLA_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic add_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic ci, input logic [7:0] es, input logic ec);
        step(1'b1, a, b, ci);
        check({tag, " sum"}, 32'(Sum), 32'(es));
        check({tag, " cout"}, 32'(Cout), 32'(ec));
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        $display("add %s: %02h + %02h + %0d -> Sum=%02h Cout=%0d", tag, a, b, ci, Sum, Cout);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] model;

        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
        Cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset sum", 32'(Sum), 32'h00);
        check("reset cout", 32'(Cout), 32'd0);
        check("reset valid", 32'(out_valid), 32'd0);
`ifdef CLA_OVF_EN
        check("reset ovf", 32'(Ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        add_check("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        add_check("intra", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        add_check("allprop", 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0);
        add_check("chain", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add_check("cinprop1", 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1);
        add_check("cinprop2", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        add_check("grpgen", 8'h08, 8'h08, 1'b0, 8'h10, 1'b0);
        add_check("msbwrap", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        add_check("mixed", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // in_valid low: outputs hold, out_valid drops
        step(1'b0, 8'hFF, 8'hFF, 1'b1);
        check("hold sum", 32'(Sum), 32'h47);
        check("hold cout", 32'(Cout), 32'd0);
        check("hold valid", 32'(out_valid), 32'd0);
        $display("hold: Sum=%02h Cout=%0d out_valid=%0d", Sum, Cout, out_valid);

        add_check("b2b1", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        add_check("b2b2", 8'h02, 8'h02, 1'b0, 8'h04, 1'b0);

        // reset coincides with a valid input: the result is dropped
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 8'hFF, 8'hFF, 1'b1);
        check("rstpend sum", 32'(Sum), 32'h00);
        check("rstpend cout", 32'(Cout), 32'd0);
        check("rstpend valid", 32'(out_valid), 32'd0);
        $display("reset while pending: Sum=%02h Cout=%0d out_valid=%0d", Sum, Cout, out_valid);
        @(negedge clk);
        rst = 1'b0;

`ifdef CLA_OVF_EN
        add_check("ovfpos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        check("ovfpos ovf", 32'(Ovf), 32'd1);
        add_check("ovfneg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        check("ovfneg ovf", 32'(Ovf), 32'd1);
        add_check("noovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        check("noovf ovf", 32'(Ovf), 32'd0);
`endif

        for (int i = 0; i < 200; i++) begin
            ra    = 8'($urandom_range(255));
            rb    = 8'($urandom_range(255));
            rc    = 1'($urandom_range(1));
            model = 9'(ra) + 9'(rb) + 9'(rc);
            add_check("rand", ra, rb, rc, model[7:0], model[8]);
`ifdef CLA_OVF_EN
            check("rand ovf", 32'(Ovf), 32'((ra[7] == rb[7]) && (model[7] != ra[7])));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
